regwrite_arbiter: RTL and testbench
===================================

Name: regwrite_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
- Requester 0 is the integer ALU/load writeback; requester 1 is the FP move unit (int->fp and fp->int moves).
- Each requester has a one-entry holding buffer. A round-robin grant drives a registered write command (write, fpoint, destination, data) into the register file.
- Exports per-file pending-destination masks so issue logic can stall on read-after-write hazards.

Parameters:
- DW, 32, data width of the write bus
- AW, 5, register index width (32 registers per file)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  requester 0 has a write to offer
- r0_ready  output  1  requester 0 buffer can accept this cycle
- r0_dest  input  AW  requester 0 destination register
- r0_fp  input  2  requester 0 fpoint code
- r0_data  input  DW  requester 0 write data
- r1_valid, r1_ready, r1_dest, r1_fp, r1_data  same as r0_*, for requester 1
- stall  input  1  suppresses grants this cycle; buffers hold
- rf_write  output  1  register file write enable
- rf_fpoint  output  2  fpoint code to the register file
- rf_rw  output  AW  write index (the register file's regdst is tied to select rd)
- rf_busW  output  DW  write data
- pend_int  output  2^AW  integer destinations with a buffered write
- pend_fp  output  2^AW  FP destinations with a buffered write

Behaviour:
- Reset (synchronous, active-high): both buffers empty. rf_write=0, rf_fpoint=0, rf_rw=0, rf_busW=0. pend_int=0, pend_fp=0. Last-grant pointer lg=1, so requester 0 wins the first contention.
- Reset asserted mid-operation discards buffered writes. No rf_write pulse occurs on the reset edge or on the cycle after it.
- Accept: a transfer on requester i happens when ri_valid & ri_ready at a rising edge. The buffer latches dest, fp and data and is marked full.
- ri_ready is combinational: ri_ready = !reset & (buffer i empty | buffer i granted this cycle). A drain and a new fill of the same buffer may occur in one cycle.
- Grant: evaluated combinationally each cycle on full buffers, only when stall=0.
  - Only one buffer full: that buffer is granted.
  - Both full: grant requester !lg, then update lg to the winner. Worst-case wait is 1 grant.
- Output: a grant at edge k loads rf_write=1 and rf_fpoint/rf_rw/rf_busW from the winning buffer. The buffer empties at edge k.
  - rf_write is a one-cycle pulse per grant. It is 0 in any cycle following an edge with no grant.
  - rf_fpoint/rf_rw/rf_busW hold their last values when rf_write=0.
- Latency: accept at edge k -> earliest rf_write=1 during the cycle after edge k+1. Sustained throughput is 1 write/cycle total.
- Pending masks: combinational from buffer contents, not from the output register.
  - A full buffer with fp==1 sets pend_fp[dest].
  - A full buffer with fp==0, 2 or 3 sets pend_int[dest].
  - Both buffers may target the same index; the bit stays set until both have drained.
- Same-destination ordering: if both buffers hold the same (file, dest), grant order follows round-robin, not arrival. Requesters guarantee they never issue two outstanding writes to one destination.
- stall=1: no grant, rf_write=0 next cycle, lg unchanged. Buffers still accept if empty.
- fp code passes through unmodified; the arbiter does not interpret data. Register 0 is not special-cased.

Test Plan:
- Reset, then r0 offers dest=5, fp=0, data=0x0000_00AA for one cycle -> r0_ready=1. pend_int[5]=1 for one cycle. rf_write=1, rf_rw=5, rf_fpoint=0, rf_busW=0xAA two edges after the offer. pend_int returns to 0.
- Both requesters offer every cycle: r0 with data 0x100+n, r1 with fp=1 and data 0x200+n -> rf_write=1 every cycle with alternating sources, starting r0. Each requester's ready toggles at a 50% duty. No data is lost or duplicated over 20 writes.
- Both buffers full and stall held for 3 cycles -> rf_write=0 for 3 cycles and both readies=0. After stall drops, r0 then r1 are written on consecutive cycles.
- r1 offers fp=1 dest=7, and r0 offers fp=2 dest=7 in the same cycle -> pend_fp[7]=1 and pend_int[7]=1 simultaneously. Each clears only when its own buffer drains.
- reset asserted while both buffers are full -> no rf_write pulse after the reset edge, pend masks=0, and r0 wins the next contention.
- r0 streams back-to-back with no contention -> r0_ready stays 1 continuously (drain+refill), and rf_write=1 every cycle.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: shares the register file write port between the
// integer ALU/load writeback (r0) and the FP move unit (r1).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rN_valid/ready        offer handshake for requester N (N = 0, 1)
//   rN_dest/fp/data       destination, fpoint code and data of the offer
//   stall                 suppresses grants; buffers hold their contents
//   rf_write/fpoint/rw/busW  registered write command to the register file
//   pend_int/pend_fp      per-file masks of destinations with a buffered write
module regwrite_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r0_valid,
    output logic                 r0_ready,
    input  logic [AW-1:0]        r0_dest,
    input  logic [1:0]           r0_fp,
    input  logic [DW-1:0]        r0_data,
    input  logic                 r1_valid,
    output logic                 r1_ready,
    input  logic [AW-1:0]        r1_dest,
    input  logic [1:0]           r1_fp,
    input  logic [DW-1:0]        r1_data,
    input  logic                 stall,
    output logic                 rf_write,
    output logic [1:0]           rf_fpoint,
    output logic [AW-1:0]        rf_rw,
    output logic [DW-1:0]        rf_busW,
    output logic [(1<<AW)-1:0]   pend_int,
    output logic [(1<<AW)-1:0]   pend_fp
);

    logic          b0_full;
    logic [AW-1:0] b0_dest;
    logic [1:0]    b0_fp;
    logic [DW-1:0] b0_data;
    logic          b1_full;
    logic [AW-1:0] b1_dest;
    logic [1:0]    b1_fp;
    logic [DW-1:0] b1_data;

    // Last-grant pointer: on contention the other requester wins.
    logic lg;
    logic both;
    logic gnt0;
    logic gnt1;

    assign both = b0_full & b1_full;
    assign gnt0 = !stall & b0_full & (!b1_full | lg);
    assign gnt1 = !stall & b1_full & (!b0_full | !lg);

    // A buffer being drained this cycle can be refilled at the same edge.
    assign r0_ready = !reset & (!b0_full | gnt0);
    assign r1_ready = !reset & (!b1_full | gnt1);

    // fp code 1 names the FP file; every other code names the integer file.
    always_comb begin
        pend_int = '0;
        pend_fp  = '0;
        if (b0_full) begin
            if (b0_fp == 2'd1) pend_fp[b0_dest]  = 1'b1;
            else               pend_int[b0_dest] = 1'b1;
        end
        if (b1_full) begin
            if (b1_fp == 2'd1) pend_fp[b1_dest]  = 1'b1;
            else               pend_int[b1_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b0_full   <= 1'b0;
            b0_dest   <= '0;
            b0_fp     <= '0;
            b0_data   <= '0;
            b1_full   <= 1'b0;
            b1_dest   <= '0;
            b1_fp     <= '0;
            b1_data   <= '0;
            lg        <= 1'b1;
            rf_write  <= 1'b0;
            rf_fpoint <= '0;
            rf_rw     <= '0;
            rf_busW   <= '0;
        end else begin
            rf_write <= gnt0 | gnt1;
            if (gnt0) begin
                rf_fpoint <= b0_fp;
                rf_rw     <= b0_dest;
                rf_busW   <= b0_data;
            end else if (gnt1) begin
                rf_fpoint <= b1_fp;
                rf_rw     <= b1_dest;
                rf_busW   <= b1_data;
            end
            // The pointer only moves when there was a real contention.
            if (both & !stall) lg <= gnt1;
            if (r0_valid & r0_ready) begin
                b0_full <= 1'b1;
                b0_dest <= r0_dest;
                b0_fp   <= r0_fp;
                b0_data <= r0_data;
            end else if (gnt0) begin
                b0_full <= 1'b0;
            end
            if (r1_valid & r1_ready) begin
                b1_full <= 1'b1;
                b1_dest <= r1_dest;
                b1_fp   <= r1_fp;
                b1_data <= r1_data;
            end else if (gnt1) begin
                b1_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: scenario tasks plus a randomized run, checked
// against a queue-style reference model of the two holding buffers.
module tb_regwrite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [4:0]  r0_dest, r1_dest;
    logic [1:0]  r0_fp, r1_fp;
    logic [31:0] r0_data, r1_data;
    logic        stall;
    logic        rf_write;
    logic [1:0]  rf_fpoint;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busW;
    logic [31:0] pend_int, pend_fp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regwrite_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_dest(r0_dest),
        .r0_fp(r0_fp), .r0_data(r0_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_dest(r1_dest),
        .r1_fp(r1_fp), .r1_data(r1_data),
        .stall(stall),
        .rf_write(rf_write), .rf_fpoint(rf_fpoint), .rf_rw(rf_rw),
        .rf_busW(rf_busW), .pend_int(pend_int), .pend_fp(pend_fp)
    );

    // Reference model: one slot per requester, last winner, expected command.
    bit          mfull[2];
    logic [4:0]  mdest[2];
    logic [1:0]  mfp[2];
    logic [31:0] mdata[2];
    bit          mlg;
    bit          mrdy[2];
    logic        ew;
    logic [1:0]  efp;
    logic [4:0]  erw;
    logic [31:0] ebus;
    logic [31:0] epi, epf;
    // DUT combinational outputs captured just before the edge.
    logic        crdy[2];
    logic [31:0] cpi, cpf;

    task automatic drive_cycle(
        input bit v0, input logic [4:0] d0, input logic [1:0] f0, input logic [31:0] x0,
        input bit v1, input logic [4:0] d1, input logic [1:0] f1, input logic [31:0] x1,
        input bit st);
        int win;
        bit v[2];
        logic [4:0] d[2];
        logic [1:0] f[2];
        logic [31:0] x[2];
        v[0] = v0; d[0] = d0; f[0] = f0; x[0] = x0;
        v[1] = v1; d[1] = d1; f[1] = f1; x[1] = x1;
        r0_valid = v0; r0_dest = d0; r0_fp = f0; r0_data = x0;
        r1_valid = v1; r1_dest = d1; r1_fp = f1; r1_data = x1;
        stall = st;
        win = -1;
        if (!st) begin
            if (mfull[0] && mfull[1]) win = mlg ? 0 : 1;
            else if (mfull[0]) win = 0;
            else if (mfull[1]) win = 1;
        end
        epi = '0;
        epf = '0;
        for (int i = 0; i < 2; i++) begin
            mrdy[i] = !rst && (!mfull[i] || win == i);
            if (mfull[i]) begin
                if (mfp[i] == 2'd1) epf[mdest[i]] = 1'b1;
                else                epi[mdest[i]] = 1'b1;
            end
        end
        #1;
        crdy[0] = r0_ready; crdy[1] = r1_ready;
        cpi = pend_int; cpf = pend_fp;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2; i++) mfull[i] = 1'b0;
            mlg = 1'b1;
            ew = 1'b0; efp = '0; erw = '0; ebus = '0;
        end else begin
            ew = (win >= 0);
            if (win >= 0) begin
                efp = mfp[win]; erw = mdest[win]; ebus = mdata[win];
            end
            if (mfull[0] && mfull[1] && !st) mlg = (win == 1);
            for (int i = 0; i < 2; i++) begin
                if (v[i] && mrdy[i]) begin
                    mfull[i] = 1'b1; mdest[i] = d[i]; mfp[i] = f[i]; mdata[i] = x[i];
                end else if (win == i) begin
                    mfull[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit st);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(0);
        idle(0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(0);
        idle(0);
        tests++; if (crdy[0] !== 1'b0 || crdy[1] !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b%b exp=00", crdy[0], crdy[1]); end
        tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL reset_write got=%b exp=0", rf_write); end
        tests++; if ({rf_fpoint, rf_rw, rf_busW} !== '0) begin fails++; $display("FAIL reset_cmd got=%h/%h/%h exp=0", rf_fpoint, rf_rw, rf_busW); end
        tests++; if (pend_int !== '0 || pend_fp !== '0) begin fails++; $display("FAIL reset_pend got=%h/%h exp=0", pend_int, pend_fp); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        drive_cycle(1, 5, 0, 32'hAA, 0, 0, 0, 0, 0);
        tests++; if (crdy[0] !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", crdy[0]); end
        tests++; if (pend_int !== 32'h20) begin fails++; $display("FAIL single_pend got=%h exp=00000020", pend_int); end
        tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL single_early got=%b exp=0", rf_write); end
        idle(0);
        tests++; if (rf_write !== 1'b1 || rf_rw !== 5'd5 || rf_fpoint !== 2'd0 || rf_busW !== 32'hAA) begin
            fails++; $display("FAIL single_write got=%b/%0d/%0d/%h exp=1/5/0/aa", rf_write, rf_rw, rf_fpoint, rf_busW);
        end
        tests++; if (pend_int !== '0) begin fails++; $display("FAIL single_pend_clr got=%h exp=0", pend_int); end
        idle(0);
        tests++; if (rf_write !== 1'b0 || rf_rw !== 5'd5 || rf_busW !== 32'hAA) begin
            fails++; $display("FAIL single_hold got=%b/%0d/%h exp=0/5/aa", rf_write, rf_rw, rf_busW);
        end
    endtask

    task automatic test_alternate();
        int n0 = 0, n1 = 0;
        logic [31:0] wd[$];
        logic [1:0]  wf[$];
        do_reset();
        for (int c = 0; c < 22; c++) begin
            drive_cycle(1, 5'(n0), 0, 32'h100 + n0, 1, 5'(n1), 1, 32'h200 + n1, 0);
            if (crdy[0]) n0++;
            if (crdy[1]) n1++;
            if (c >= 1) begin
                tests++; if (crdy[0] === crdy[1]) begin fails++; $display("FAIL alt_ready c=%0d got=%b%b exp=toggling", c, crdy[0], crdy[1]); end
                tests++; if (rf_write !== 1'b1) begin fails++; $display("FAIL alt_write c=%0d got=%b exp=1", c, rf_write); end
            end
            if (rf_write === 1'b1) begin wd.push_back(rf_busW); wf.push_back(rf_fpoint); end
        end
        tests++; if (wd.size() < 20) begin fails++; $display("FAIL alt_count got=%0d exp>=20", wd.size()); end
        for (int w = 0; w < 20 && w < wd.size(); w++) begin
            logic [31:0] ed = (w % 2 == 0) ? 32'h100 + w / 2 : 32'h200 + w / 2;
            logic [1:0]  ef = (w % 2 == 0) ? 2'd0 : 2'd1;
            tests++; if (wd[w] !== ed || wf[w] !== ef) begin
                fails++; $display("FAIL alt_data w=%0d got=%h/%0d exp=%h/%0d", w, wd[w], wf[w], ed, ef);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive_cycle(1, 3, 0, 32'h33, 1, 4, 1, 32'h44, 0);
        for (int c = 0; c < 3; c++) begin
            idle(1);
            tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL stall_write c=%0d got=%b exp=0", c, rf_write); end
            tests++; if (crdy[0] !== 1'b0 || crdy[1] !== 1'b0) begin fails++; $display("FAIL stall_ready c=%0d got=%b%b exp=00", c, crdy[0], crdy[1]); end
        end
        idle(0);
        tests++; if (rf_write !== 1'b1 || rf_rw !== 5'd3 || rf_busW !== 32'h33) begin
            fails++; $display("FAIL stall_first got=%b/%0d/%h exp=1/3/33", rf_write, rf_rw, rf_busW);
        end
        idle(0);
        tests++; if (rf_write !== 1'b1 || rf_rw !== 5'd4 || rf_fpoint !== 2'd1 || rf_busW !== 32'h44) begin
            fails++; $display("FAIL stall_second got=%b/%0d/%0d/%h exp=1/4/1/44", rf_write, rf_rw, rf_fpoint, rf_busW);
        end
        idle(0);
        tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL stall_after got=%b exp=0", rf_write); end
    endtask

    task automatic test_samedest();
        do_reset();
        drive_cycle(1, 7, 2, 32'h71, 1, 7, 1, 32'h72, 0);
        tests++; if (pend_int[7] !== 1'b1 || pend_fp[7] !== 1'b1) begin
            fails++; $display("FAIL same_both got=%b/%b exp=1/1", pend_int[7], pend_fp[7]);
        end
        idle(0);
        tests++; if (pend_int[7] !== 1'b0 || pend_fp[7] !== 1'b1 || rf_fpoint !== 2'd2) begin
            fails++; $display("FAIL same_first got=%b/%b/%0d exp=0/1/2", pend_int[7], pend_fp[7], rf_fpoint);
        end
        idle(0);
        tests++; if (pend_fp !== '0 || rf_fpoint !== 2'd1 || rf_rw !== 5'd7) begin
            fails++; $display("FAIL same_second got=%h/%0d/%0d exp=0/1/7", pend_fp, rf_fpoint, rf_rw);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1, 9, 0, 32'h91, 1, 10, 1, 32'h92, 0);
        drive_cycle(1, 13, 0, 32'h93, 1, 14, 1, 32'h94, 0);
        idle(1);
        rst = 1'b1;
        idle(0);
        tests++; if (crdy[0] !== 1'b0 || crdy[1] !== 1'b0) begin fails++; $display("FAIL mid_ready got=%b%b exp=00", crdy[0], crdy[1]); end
        tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL mid_edge_write got=%b exp=0", rf_write); end
        tests++; if (pend_int !== '0 || pend_fp !== '0) begin fails++; $display("FAIL mid_pend got=%h/%h exp=0", pend_int, pend_fp); end
        rst = 1'b0;
        idle(0);
        tests++; if (rf_write !== 1'b0) begin fails++; $display("FAIL mid_next_write got=%b exp=0", rf_write); end
        drive_cycle(1, 11, 0, 32'hB1, 1, 12, 1, 32'hB2, 0);
        idle(0);
        tests++; if (rf_write !== 1'b1 || rf_rw !== 5'd11 || rf_busW !== 32'hB1) begin
            fails++; $display("FAIL mid_winner got=%b/%0d/%h exp=1/11/b1", rf_write, rf_rw, rf_busW);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, 5'(i), 0, 32'hC00 + i, 0, 0, 0, 0, 0);
            tests++; if (crdy[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, crdy[0]); end
            if (i >= 1) begin
                tests++; if (rf_write !== 1'b1 || rf_busW !== 32'hC00 + i - 1) begin
                    fails++; $display("FAIL b2b_write i=%0d got=%b/%h exp=1/%h", i, rf_write, rf_busW, 32'hC00 + i - 1);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(99) < 3);
            drive_cycle($urandom_range(99) < 60, 5'($urandom), 2'($urandom), $urandom,
                        $urandom_range(99) < 60, 5'($urandom), 2'($urandom), $urandom,
                        $urandom_range(99) < 20);
            tests++; if (crdy[0] !== mrdy[0] || crdy[1] !== mrdy[1]) begin
                fails++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, crdy[0], crdy[1], mrdy[0], mrdy[1]);
            end
            tests++; if (cpi !== epi || cpf !== epf) begin
                fails++; $display("FAIL rnd_pend c=%0d got=%h/%h exp=%h/%h", c, cpi, cpf, epi, epf);
            end
            tests++; if (rf_write !== ew || rf_fpoint !== efp || rf_rw !== erw || rf_busW !== ebus) begin
                fails++; $display("FAIL rnd_cmd c=%0d got=%b/%0d/%0d/%h exp=%b/%0d/%0d/%h",
                                  c, rf_write, rf_fpoint, rf_rw, rf_busW, ew, efp, erw, ebus);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) mfull[i] = 1'b0;
        mlg = 1'b1;
        ew = 1'b0; efp = '0; erw = '0; ebus = '0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_samedest();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
